cam_cfg_sequencer: RTL

//  Walks a register table and programs the camera over SCCB after the config-start pulse from system control.

---
 rtl/cam_cfg_pkg.sv | 6 +
 rtl/cam_cfg_rom.sv | 22 ++
 rtl/cam_cfg_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared table encodings and sequencer states for the camera config block.
package cam_cfg_pkg;
    localparam logic [15:0] CFG_END      = 16'hFFFF;
    localparam logic [7:0]  CFG_DLY_ADDR = 8'hFF;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, DONE, ERR} state_t;
endpackage

// File: rtl/cam_cfg_rom.sv
// cam_cfg_rom: 2**ROM_AW x 16 register table with a registered (1-cycle) read.
module cam_cfg_rom #(
    parameter int                          ROM_AW   = 7,
    parameter logic [16*(2**ROM_AW)-1:0]   ROM_INIT = '1
) (
    input  logic              i_clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [15:0]       o_data
);
    logic [15:0] rom [2**ROM_AW];
    logic [15:0] data_q, data_d;

    for (genvar i = 0; i < 2**ROM_AW; i++) begin : g_rom
        assign rom[i] = ROM_INIT[16*i +: 16];
    end

    always_comb data_d = rom[i_addr];

    always_ff @(posedge i_clk) data_q <= data_d;

    assign o_data = data_q;
endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks the register table and issues SCCB writes, honouring delay entries.
// Define CAM_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before aborting.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int                        CLK_HZ    = 25_000_000,
    parameter int                        ROM_AW    = 7,
`ifdef CAM_CFG_RETRY_EN
    parameter int                        MAX_RETRY = 3,
`endif
    parameter logic [16*(2**ROM_AW)-1:0] ROM_INIT  = '1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cfg_start,
    output logic              o_sccb_valid,
    input  logic              i_sccb_ready,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    input  logic              i_sccb_done,
    input  logic              i_sccb_nack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ROM_AW-1:0] o_err_idx
);
    localparam int TICKS = CLK_HZ / 1000;
    localparam int TW    = TICKS > 1 ? $clog2(TICKS) : 1;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] idx_q, idx_d;
    logic [15:0]       entry_q, entry_d;
    logic [7:0]        dly_q, dly_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [15:0]       rom_data;
    logic              adv;
`ifdef CAM_CFG_RETRY_EN
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0]     retry_q, retry_d;
`endif

    cam_cfg_rom #(.ROM_AW(ROM_AW), .ROM_INIT(ROM_INIT)) u_rom (
        .i_clk  (i_clk),
        .i_addr (idx_q),
        .o_data (rom_data)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            entry_q <= '0;
            dly_q   <= '0;
            tick_q  <= '0;
`ifdef CAM_CFG_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            entry_q <= entry_d;
            dly_q   <= dly_d;
            tick_q  <= tick_d;
`ifdef CAM_CFG_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // A finished delay moves on exactly like an acknowledged write.
    assign adv = (state_q == WAIT_ACK && i_sccb_done && !i_sccb_nack) ||
                 (state_q == DELAY && dly_q == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        entry_d = entry_q;
        dly_d   = dly_q;
        tick_d  = tick_q;
`ifdef CAM_CFG_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: if (i_cfg_start) begin
                state_d = FETCH;
                idx_d   = '0;
            end
            FETCH: begin
                state_d = DECODE;
`ifdef CAM_CFG_RETRY_EN
                retry_d = '0;
`endif
            end
            DECODE: begin
                entry_d = rom_data;
                dly_d   = rom_data[7:0];
                tick_d  = '0;
                state_d = rom_data == CFG_END ? DONE :
                          rom_data[15:8] == CFG_DLY_ADDR ? DELAY : ISSUE;
            end
            ISSUE: if (i_sccb_ready) state_d = WAIT_ACK;
            WAIT_ACK: if (i_sccb_done && i_sccb_nack) begin
`ifdef CAM_CFG_RETRY_EN
                if (retry_q == RW'(MAX_RETRY)) state_d = ERR;
                else begin
                    state_d = ISSUE;
                    retry_d = retry_q + 1'b1;
                end
`else
                state_d = ERR;
`endif
            end
            DELAY: if (dly_q != '0) begin
                tick_d = tick_q == TW'(TICKS - 1) ? '0 : tick_q + 1'b1;
                dly_d  = tick_q == TW'(TICKS - 1) ? dly_q - 1'b1 : dly_q;
            end
            default: state_d = IDLE;
        endcase
        // The last table slot ends the sequence rather than wrapping to index 0.
        if (adv) begin
            state_d = &idx_q ? DONE : FETCH;
            idx_d   = &idx_q ? idx_q : idx_q + 1'b1;
        end
    end

    always_comb begin
        o_sccb_valid = state_q == ISSUE;
        o_sccb_addr  = entry_q[15:8];
        o_sccb_data  = entry_q[7:0];
        o_busy       = !(state_q inside {IDLE, DONE, ERR});
        o_done       = state_q == DONE;
        o_err        = state_q == ERR;
        o_err_idx    = state_q == ERR ? idx_q : '0;
    end
endmodule
